// File: rtl/sdram_resp_pkg.sv
// Shared command encoding, mode-register field layout and burst-length codes
// for the SDRAM device-side responder.
package sdram_resp_pkg;

   typedef enum logic [2:0] {
      CMD_NOP,
      CMD_ACTIVE,
      CMD_READ,
      CMD_WRITE,
      CMD_PRECHARGE,
      CMD_REFRESH,
      CMD_LOAD_MODE,
      CMD_BURST_TERM
   } cmd_e;

   typedef enum logic [1:0] {
      BST_IDLE,
      BST_READ,
      BST_WRITE
   } bst_e;

   localparam int MODE_BL_LSB  = 0;
   localparam int MODE_BL_MSB  = 2;
   localparam int MODE_CAS_LSB = 4;
   localparam int MODE_CAS_MSB = 6;

   localparam logic [1:0] BL_1 = 2'd0;
   localparam logic [1:0] BL_2 = 2'd1;
   localparam logic [1:0] BL_4 = 2'd2;
   localparam logic [1:0] BL_8 = 2'd3;

   localparam logic [2:0] CAS_RESET = 3'd3;

   // pins = {cs_n, ras_n, cas_n, we_n}; deselect decodes as NOP
   function automatic cmd_e sdram_decode(input logic [3:0] pins);
      cmd_e c;
      c = CMD_NOP;
      if (!pins[3]) begin
         case (pins[2:0])
            3'b011:  c = CMD_ACTIVE;
            3'b101:  c = CMD_READ;
            3'b100:  c = CMD_WRITE;
            3'b010:  c = CMD_PRECHARGE;
            3'b001:  c = CMD_REFRESH;
            3'b000:  c = CMD_LOAD_MODE;
            3'b110:  c = CMD_BURST_TERM;
            default: c = CMD_NOP;
         endcase
      end
      return c;
   endfunction

   // Index of the last beat (BL-1), which doubles as the column wrap mask
   function automatic logic [2:0] bl_last(input logic [1:0] code);
      logic [2:0] r;
      case (code)
         BL_1:    r = 3'd0;
         BL_2:    r = 3'd1;
         BL_4:    r = 3'd3;
         default: r = 3'd7;
      endcase
      return r;
   endfunction

endpackage

// File: rtl/sdram_rd_pipe.sv
// Read-data delay line: beats enter at the generating edge and leave through a
// CAS-selected tap into registered dq outputs; dqm masks with 2-cycle latency.
module sdram_rd_pipe
   import sdram_resp_pkg::*;
#(
   parameter int DQ_W = 8
) (
   input  logic            clk,
   input  logic            reset,
   input  logic            cke,
   input  logic            in_vld,
   input  logic [DQ_W-1:0] in_data,
   input  logic            dqm,
   input  logic            tap3,
   output logic [DQ_W-1:0] dq_out,
   output logic            dq_oe
);

   logic [DQ_W-1:0] data_q [3];
   logic [2:0]      vld_q;
   logic [1:0]      dqm_q;
   logic [DQ_W-1:0] out_q;
   logic            oe_q;
   logic            tap_vld;
   logic [DQ_W-1:0] tap_data;

   assign tap_vld  = tap3 ? vld_q[2]  : vld_q[1];
   assign tap_data = tap3 ? data_q[2] : data_q[1];

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         for (int i = 0; i < 3; i++) data_q[i] <= '0;
         vld_q <= '0;
         dqm_q <= '0;
         out_q <= '0;
         oe_q  <= 1'b0;
      end else if (cke) begin
         data_q[0] <= in_data;
         data_q[1] <= data_q[0];
         data_q[2] <= data_q[1];
         vld_q     <= {vld_q[1:0], in_vld};
         dqm_q     <= {dqm_q[0], dqm};
         oe_q      <= tap_vld & ~dqm_q[1];
         out_q     <= tap_vld ? tap_data : '0;
      end
   end

   assign dq_out = out_q;
   assign dq_oe  = oe_q;

endmodule

// File: rtl/sdram_cmd_responder.sv
// SDRAM device-side responder: command decode, mode register, open-row tracking,
// burst engine and small backing store. Optional tRCD check: SDRAM_RESP_TIMING_CHECK_EN.
module sdram_cmd_responder
   import sdram_resp_pkg::*;
#(
   parameter int DQ_W   = 8,
   parameter int ADDR_W = 13,
   parameter int COL_W  = 8,
   parameter int MEM_AW = 10,
   parameter int T_RCD  = 2
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              cke,
   input  logic              cs_n,
   input  logic              ras_n,
   input  logic              cas_n,
   input  logic              we_n,
   input  logic [1:0]        ba,
   input  logic [ADDR_W-1:0] addr,
   input  logic              dqm,
   input  logic [DQ_W-1:0]   dq_in,
   output logic [DQ_W-1:0]   dq_out,
   output logic              dq_oe,
   output logic [2:0]        mode_cas,
   output logic [15:0]       rfsh_cnt,
   output logic              cmd_err
);

   localparam int IDX_COL_W = MEM_AW - 4;

   cmd_e              cmd;
   bst_e              bst_state_q, bst_state_d;
   logic [1:0]        bst_bank_q, bst_bank_d;
   logic [1:0]        bst_row_q, bst_row_d;
   logic [COL_W-1:0]  bst_start_q, bst_start_d;
   logic [2:0]        bst_beat_q, bst_beat_d;
   logic [2:0]        bst_last_q, bst_last_d;
   logic              bst_ap_q, bst_ap_d;
   logic [3:0]        open_q, open_d;
   logic [ADDR_W-1:0] row_q [4];
   logic [ADDR_W-1:0] row_d [4];
   logic [2:0]        cas_q, cas_d;
   logic [1:0]        bl_q, bl_d;
   logic [15:0]       rfsh_q, rfsh_d;
   logic              err_q, err_d;

   logic              beat_vld, beat_wr, mem_we, start, stop, rcd_early;
   logic [COL_W-1:0]  beat_col, col_mask;
   logic [MEM_AW-1:0] beat_idx;
   logic [DQ_W-1:0]   mem_q [2**MEM_AW];
   logic              unused_bits;

   assign cmd = sdram_decode({cs_n, ras_n, cas_n, we_n});
   assign col_mask = {{(COL_W-3){1'b0}}, bst_last_q};

`ifdef SDRAM_RESP_TIMING_CHECK_EN
   localparam logic [3:0] RCD_LOAD = 4'((T_RCD > 0) ? T_RCD - 1 : 0);
   logic [3:0] rcd_q [4];
   logic [3:0] rcd_d [4];

   // Counters run on every clock, so they measure real cycles since ACTIVE
   always_comb begin
      for (int i = 0; i < 4; i++) rcd_d[i] = (rcd_q[i] != 4'd0) ? rcd_q[i] - 4'd1 : 4'd0;
      if (cke && cmd == CMD_ACTIVE) rcd_d[ba] = RCD_LOAD;
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         for (int i = 0; i < 4; i++) rcd_q[i] <= '0;
      end else begin
         for (int i = 0; i < 4; i++) rcd_q[i] <= rcd_d[i];
      end
   end

   assign rcd_early = (rcd_q[ba] != 4'd0);
`else
   assign rcd_early = 1'b0;
`endif

   always_comb begin
      bst_state_d = bst_state_q;
      bst_bank_d  = bst_bank_q;
      bst_row_d   = bst_row_q;
      bst_start_d = bst_start_q;
      bst_beat_d  = bst_beat_q;
      bst_last_d  = bst_last_q;
      bst_ap_d    = bst_ap_q;
      open_d      = open_q;
      row_d       = row_q;
      cas_d       = cas_q;
      bl_d        = bl_q;
      rfsh_d      = rfsh_q;
      err_d       = 1'b0;
      start       = 1'b0;
      stop        = 1'b0;
      beat_vld    = 1'b0;
      beat_wr     = 1'b0;
      beat_col    = '0;
      beat_idx    = '0;
      if (cke) begin
         case (cmd)
            CMD_ACTIVE: begin
               if (open_q[ba]) err_d = 1'b1;
               open_d[ba] = 1'b1;
               row_d[ba]  = addr;
            end
            CMD_PRECHARGE: begin
               if (addr[10]) open_d = '0;
               else          open_d[ba] = 1'b0;
               if (bst_state_q != BST_IDLE && (addr[10] || ba == bst_bank_q)) stop = 1'b1;
            end
            CMD_REFRESH: begin
               rfsh_d = (rfsh_q == 16'hFFFF) ? rfsh_q : rfsh_q + 16'd1;
               if (|open_q) err_d = 1'b1;
            end
            CMD_LOAD_MODE: begin
               if (addr[MODE_CAS_MSB:MODE_CAS_LSB] inside {3'd2, 3'd3}) begin
                  cas_d = addr[MODE_CAS_MSB:MODE_CAS_LSB];
                  if (addr[MODE_BL_MSB]) begin
                     bl_d  = BL_8;
                     err_d = 1'b1;
                  end else begin
                     bl_d = addr[MODE_BL_MSB-1:MODE_BL_LSB];
                  end
               end else begin
                  err_d = 1'b1;
               end
            end
            CMD_BURST_TERM: stop = 1'b1;
            CMD_READ, CMD_WRITE: begin
               if (!open_q[ba]) err_d = 1'b1;
               else begin
                  start = 1'b1;
                  if (rcd_early) err_d = 1'b1;
               end
            end
            default: ;
         endcase

         // A new burst always wins over the beat of the burst it replaces
         if (start) begin
            beat_vld    = 1'b1;
            beat_wr     = (cmd == CMD_WRITE);
            beat_col    = addr[COL_W-1:0];
            beat_idx    = {ba, row_q[ba][1:0], beat_col[IDX_COL_W-1:0]};
            bst_bank_d  = ba;
            bst_row_d   = row_q[ba][1:0];
            bst_start_d = addr[COL_W-1:0];
            bst_beat_d  = 3'd1;
            bst_last_d  = bl_last(bl_q);
            bst_ap_d    = addr[10];
            if (bl_q == BL_1) begin
               bst_state_d = BST_IDLE;
               if (addr[10]) open_d[ba] = 1'b0;
            end else begin
               bst_state_d = (cmd == CMD_WRITE) ? BST_WRITE : BST_READ;
            end
         end else if (stop) begin
            bst_state_d = BST_IDLE;
         end else if (bst_state_q != BST_IDLE) begin
            beat_vld   = 1'b1;
            beat_wr    = (bst_state_q == BST_WRITE);
            beat_col   = (bst_start_q & ~col_mask) |
                         ((bst_start_q + {{(COL_W-3){1'b0}}, bst_beat_q}) & col_mask);
            beat_idx   = {bst_bank_q, bst_row_q, beat_col[IDX_COL_W-1:0]};
            bst_beat_d = bst_beat_q + 3'd1;
            if (bst_beat_q == bst_last_q) begin
               bst_state_d = BST_IDLE;
               if (bst_ap_q) open_d[bst_bank_q] = 1'b0;
            end
         end
      end
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         bst_state_q <= BST_IDLE;
         bst_bank_q  <= '0;
         bst_row_q   <= '0;
         bst_start_q <= '0;
         bst_beat_q  <= '0;
         bst_last_q  <= '0;
         bst_ap_q    <= 1'b0;
         open_q      <= '0;
         for (int i = 0; i < 4; i++) row_q[i] <= '0;
         cas_q       <= CAS_RESET;
         bl_q        <= BL_1;
         rfsh_q      <= '0;
         err_q       <= 1'b0;
      end else begin
         bst_state_q <= bst_state_d;
         bst_bank_q  <= bst_bank_d;
         bst_row_q   <= bst_row_d;
         bst_start_q <= bst_start_d;
         bst_beat_q  <= bst_beat_d;
         bst_last_q  <= bst_last_d;
         bst_ap_q    <= bst_ap_d;
         open_q      <= open_d;
         for (int i = 0; i < 4; i++) row_q[i] <= row_d[i];
         cas_q       <= cas_d;
         bl_q        <= bl_d;
         rfsh_q      <= rfsh_d;
         err_q       <= err_d;
      end
   end

   assign mem_we = ~reset & beat_vld & beat_wr & ~dqm;

   always_ff @(posedge clk) begin
      if (mem_we) mem_q[beat_idx] <= dq_in;
   end

   sdram_rd_pipe #(.DQ_W(DQ_W)) u_rd_pipe (
      .clk     (clk),
      .reset   (reset),
      .cke     (cke),
      .in_vld  (beat_vld & ~beat_wr),
      .in_data (mem_q[beat_idx]),
      .dqm     (dqm),
      .tap3    (cas_q == 3'd3),
      .dq_out  (dq_out),
      .dq_oe   (dq_oe)
   );

   // Only the low row bits address storage; upper column bits only steer wrap
   assign unused_bits = ^{row_q[0][ADDR_W-1:2], row_q[1][ADDR_W-1:2],
                          row_q[2][ADDR_W-1:2], row_q[3][ADDR_W-1:2],
                          beat_col[COL_W-1:IDX_COL_W]};

   assign mode_cas = cas_q;
   assign rfsh_cnt = rfsh_q;
   assign cmd_err  = err_q;

endmodule

// File: doc/sdram_cmd_responder.md
Name: sdram_cmd_responder

Overview:
- Synthesizable SDRAM device-side responder, 8-bit data, 4 banks.
- Sits at the far end of the SDRAM controller's command pins (cke/cs_n/ras_n/cas_n/we_n/ba/addr/dq/dqm) in the bench.
- Decodes commands, holds the mode register, tracks open rows, stores write data in a small array, returns read bursts after the programmed CAS latency.
- Exposes decoded status (mode CAS, refresh count, error) for whitebox checking.

Parameters:
- DQ_W, 8, data width.
- ADDR_W, 13, SDRAM address bus width.
- COL_W, 8, column bits used from addr[COL_W-1:0].
- MEM_AW, 10, storage index width; index = {ba[1:0], row[1:0], col[5:0]}.
- T_RCD, 2, minimum cycles from ACTIVE to READ/WRITE on the same bank (used only with the optional feature).

Ports:
- clk  in  1  SDRAM clock; all logic on rising edge.
- reset  in  1  asynchronous, active-high reset.
- cke  in  1  clock enable; 0 = command ignored, burst/pipeline frozen.
- cs_n  in  1  chip select, active low.
- ras_n  in  1  row strobe, active low.
- cas_n  in  1  column strobe, active low.
- we_n  in  1  write enable, active low.
- ba  in  2  bank address.
- addr  in  ADDR_W  row/column/mode address.
- dqm  in  1  data mask.
- dq_in  in  DQ_W  write data from controller.
- dq_out  out  DQ_W  read data.
- dq_oe  out  1  read data valid / drive enable.
- mode_cas  out  3  current CAS latency field.
- rfsh_cnt  out  16  AUTO_REFRESH count, saturating.
- cmd_err  out  1  one-cycle pulse on an illegal command.

Behaviour:
- Reset values:
  - dq_out=0, dq_oe=0, cmd_err=0, rfsh_cnt=0.
  - mode_cas=3, burst length=1.
  - All banks idle; burst and pipeline empty.
  - Memory contents are not reset.
- Decode, on a clk edge with cke=1. {ras_n,cas_n,we_n}:
  - 111 = NOP
  - 011 = ACTIVE
  - 101 = READ
  - 100 = WRITE
  - 010 = PRECHARGE
  - 001 = AUTO_REFRESH
  - 000 = LOAD_MODE
  - 110 = BURST_TERM
  - cs_n=1 = DESELECT, treated as NOP.
- LOAD_MODE:
  - addr[2:0] sets burst length: 0→1, 1→2, 2→4, 3→8.
  - addr[6:4] sets CAS latency.
  - CAS must be 2 or 3. Any other value leaves the mode unchanged and pulses cmd_err.
  - Burst length values 4..7 are treated as 8 and pulse cmd_err.
- ACTIVE:
  - Opens bank ba with row addr; the row is latched.
  - ACTIVE to an already-open bank pulses cmd_err and replaces the row.
- PRECHARGE: closes bank ba; if addr[10]=1, closes all banks.
- AUTO_REFRESH:
  - Increments rfsh_cnt, saturating at 16'hFFFF.
  - If any bank is open, pulses cmd_err (the count still increments).
- READ/WRITE:
  - To an idle bank: pulse cmd_err, command ignored.
  - Otherwise start a burst at column addr[COL_W-1:0].
  - Beat k uses column (start & ~(BL-1)) | ((start+k) & (BL-1)), i.e. sequential wrap within the aligned block.
  - addr[10]=1 (auto-precharge) closes the bank after the last beat.
- WRITE beats:
  - Beat 0 is captured on the WRITE command edge; beat k on the k-th following enabled edge.
  - A beat with dqm=1 is not written.
- READ timing:
  - Beat k is generated internally on the k-th enabled edge after the command.
  - Beat k appears on dq_out with dq_oe=1 exactly mode_cas enabled cycles after the edge that generated it.
  - The first beat therefore appears CAS cycles after the READ edge.
  - Read-path dqm has 2-cycle latency: dqm sampled at edge t forces dq_oe=0 for the output at edge t+2.
- Interrupts:
  - A new READ/WRITE during a burst terminates the old burst immediately; read beats already in the pipeline still drain.
  - BURST_TERM stops beat generation; pipeline drains.
  - PRECHARGE of the burst's bank also terminates the burst.
- cke=0: no decode, burst counter and read pipeline hold, dq_oe holds its value.
- Simultaneous events: the command on the current edge is decoded before the current beat is updated; the new burst wins.
- Reset mid-burst clears the pipeline; dq_oe goes low asynchronously.

Optional Feature:
- Macro: SDRAM_RESP_TIMING_CHECK_EN.
- When defined, each bank has a counter loaded on ACTIVE.
  - READ/WRITE issued to that bank fewer than T_RCD cycles after its ACTIVE pulses cmd_err.
  - The command is still executed.
- When not defined, there are no timing counters and only protocol errors are flagged.

Decomposition:
- Package sdram_resp_pkg holds:
  - cmd_e enum.
  - decode function from {cs_n,ras_n,cas_n,we_n}.
  - mode field bit positions.
  - BL encoding constants.
  - CAS reset constant 3.
- One sub-module, sdram_rd_pipe: 3-deep data/valid delay line with a selectable tap (2 or 3), cke-gated hold, and dqm-delay masking.

Test Plan:
- Reset, then LOAD_MODE addr=0x032 (CAS 3, BL 4) → mode_cas=3, no cmd_err.
- ACTIVE ba=1 row=5; WRITE col=0x06 with data AA,BB,CC,DD; READ col=0x06 → dq_oe high on cycles 3..6 after READ, data AA,BB,CC,DD (columns 6,7,4,5).
- READ to idle bank 2 → cmd_err pulses one cycle, dq_oe stays 0.
- CAS 2, BL 8 read, with BURST_TERM issued 3 cycles after READ → exactly 3 valid beats.
- AUTO_REFRESH ×4 with all banks idle, then one with bank 0 open → rfsh_cnt=5, single cmd_err on the 5th.
- With SDRAM_RESP_TIMING_CHECK_EN and T_RCD=2, READ one cycle after ACTIVE → cmd_err pulse, data still returned.
